// File: rtl/ps2_scan_sequencer_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // One decoded key event as stored in the event FIFO.
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } ps2_evt_t;

  // True for either prefix byte (extended or break).
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
  endfunction

endpackage

// File: rtl/ps2_scan_sequencer_if.sv
// Byte-in / event-out bundle of the scan sequencer. FIFO_DEPTH must match the
// sequencer instance so that fifo_level has the same width on both sides.
interface ps2_scan_sequencer_if #(parameter int FIFO_DEPTH = 8);

  logic                          byte_valid;
  logic [7:0]                    byte_data;
  logic                          byte_err;
  logic                          evt_valid;
  logic                          evt_ready;
  logic [7:0]                    evt_code;
  logic                          evt_ext;
  logic                          evt_break;
  logic                          evt_repeat;
  logic [7:0]                    press_count;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          overflow;

  // Receiver and consumer side.
  modport master (
    output byte_valid, byte_data, byte_err, evt_ready,
    input  evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
    input  press_count, fifo_level, overflow
  );

  // Sequencer side.
  modport slave (
    input  byte_valid, byte_data, byte_err, evt_ready,
    output evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
    output press_count, fifo_level, overflow
  );

endinterface

// File: rtl/ps2_scan_sequencer_evt_fifo.sv
// Show-ahead event FIFO. The head reads as all zeros while empty; a push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  ps2_evt_t                push_data,
  input  logic                    pop,
  output ps2_evt_t                head,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t      mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (level_r == '0);
  assign full      = (level_r == (AW+1)'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign level     = level_r;
  assign head      = empty ? '0 : mem_r[rd_ptr_r];

  // Storage write; an entry only becomes visible once level_r counts it
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Scan-code sequencer: prefix FSM with idle timeout, typematic tagging via a
// held-key register, fresh-press counter and an event FIFO towards consumers.
module ps2_scan_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic                  clk,
  input logic                  rst,
  ps2_scan_sequencer_if.slave  bus
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_t    state_r;
  ps2_state_t    next_state_s;
  logic [TW-1:0] idle_cnt_r;
  logic          held_v_r;
  logic          held_ext_r;
  logic [7:0]    held_code_r;
  logic [7:0]    press_count_r;
  logic          overflow_r;

  logic          emit_s;
  logic          ext_s;
  logic          brk_s;
  logic          rpt_s;
  logic          held_match_s;
  logic          pop_s;
  ps2_evt_t      push_evt_s;
  ps2_evt_t      head_s;
  logic [LW-1:0] level_s;
  logic          full_s;
  logic          empty_s;

  // Prefix decode: next state and whether this byte completes a key event
  always_comb begin
    next_state_s = state_r;
    emit_s       = 1'b0;
    ext_s        = 1'b0;
    brk_s        = 1'b0;
    if (bus.byte_valid && bus.byte_err) begin
      next_state_s = ST_IDLE;
    end else if (bus.byte_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.byte_data == PS2_PFX_EXT) begin
            next_state_s = ST_GOT_E0;
          end else if (bus.byte_data == PS2_PFX_BRK) begin
            next_state_s = ST_GOT_F0;
          end else begin
            emit_s = 1'b1;
          end
        end
        ST_GOT_E0: begin
          if (bus.byte_data == PS2_PFX_BRK) begin
            next_state_s = ST_GOT_E0F0;
          end else if (bus.byte_data == PS2_PFX_EXT) begin
            next_state_s = ST_GOT_E0;
          end else begin
            next_state_s = ST_IDLE;
            emit_s       = 1'b1;
            ext_s        = 1'b1;
          end
        end
        ST_GOT_F0: begin
          if (bus.byte_data == PS2_PFX_BRK) begin
            next_state_s = ST_GOT_F0;
          end else if (bus.byte_data == PS2_PFX_EXT) begin
            next_state_s = ST_GOT_E0;
          end else begin
            next_state_s = ST_IDLE;
            emit_s       = 1'b1;
            brk_s        = 1'b1;
          end
        end
        ST_GOT_E0F0: begin
          next_state_s = ST_IDLE;
          if (is_prefix(bus.byte_data)) begin
            emit_s = 1'b0;
          end else begin
            emit_s = 1'b1;
            ext_s  = 1'b1;
            brk_s  = 1'b1;
          end
        end
        default: next_state_s = ST_IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  assign held_match_s = held_v_r && (held_ext_r == ext_s) && (held_code_r == bus.byte_data);
  assign rpt_s        = emit_s && !brk_s && held_match_s;
  assign push_evt_s   = {bus.byte_data, ext_s, brk_s, rpt_s};
  assign pop_s        = !empty_s && bus.evt_ready;

  // Prefix FSM with idle timeout, held-key tracking and fresh-press counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      idle_cnt_r    <= '0;
      held_v_r      <= 1'b0;
      held_ext_r    <= 1'b0;
      held_code_r   <= 8'h00;
      press_count_r <= 8'h00;
    end else begin
      if (bus.byte_valid) begin
        state_r    <= next_state_s;
        idle_cnt_r <= '0;
      end else if (state_r != ST_IDLE) begin
        if (idle_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
          state_r    <= ST_IDLE;
          idle_cnt_r <= '0;
        end else begin
          idle_cnt_r <= idle_cnt_r + TW'(1);
        end
      end else begin
        idle_cnt_r <= '0;
      end

      // Counting happens at decode time, whether or not the FIFO keeps the event
      if (emit_s && !brk_s && !held_match_s) begin
        held_v_r      <= 1'b1;
        held_ext_r    <= ext_s;
        held_code_r   <= bus.byte_data;
        press_count_r <= press_count_r + 8'd1;
      end else if (emit_s && brk_s && held_match_s) begin
        held_v_r <= 1'b0;
      end
    end
  end

  // Sticky record of an event dropped because the FIFO was full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (emit_s && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end
  end

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (emit_s),
    .push_data (push_evt_s),
    .pop       (pop_s),
    .head      (head_s),
    .level     (level_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign bus.evt_valid   = !empty_s;
  assign bus.evt_code    = head_s.code;
  assign bus.evt_ext     = head_s.ext;
  assign bus.evt_break   = head_s.brk;
  assign bus.evt_repeat  = head_s.rpt;
  assign bus.press_count = press_count_r;
  assign bus.fifo_level  = level_s;
  assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: expected events are queued as bytes
// are driven and compared against the FIFO head as the consumer drains it.
`timescale 1ns/1ps
module tb_ps2_scan_sequencer;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO    = 50;

  logic     clk = 1'b0;
  logic     rst;
  int       checks    = 0;
  int       failures  = 0;
  int       exp_press = 0;
  ps2_evt_t exp_q[$];
  ps2_evt_t got;
  ps2_evt_t exp_evt;

  ps2_scan_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_scan_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, active edge at posedge
  always #5 clk = ~clk;

  function automatic ps2_evt_t mk(input logic [7:0] c, input logic e, input logic b, input logic r);
    return {c, e, b, r};
  endfunction

  // Drive one byte for one cycle; called and returns at a negedge
  task automatic send(input logic [7:0] d, input logic err);
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    bus.byte_err   = err;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_err   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_err   = 1'b0;
    bus.evt_ready  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.evt_valid !== 1'b0 || bus.fifo_level !== 4'd0) begin
      failures++; $display("FAIL reset_held valid=%b level=%0d want 0/0", bus.evt_valid, bus.fifo_level);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.evt_valid, bus.evt_code, bus.evt_ext, bus.evt_break, bus.evt_repeat} !== 12'h000) begin
      failures++; $display("FAIL reset_evt got=%b%h%b%b%b want all zero", bus.evt_valid, bus.evt_code,
                           bus.evt_ext, bus.evt_break, bus.evt_repeat);
    end
    checks++;
    if (bus.press_count !== 8'd0 || bus.overflow !== 1'b0) begin
      failures++; $display("FAIL reset_cnt press=%0d ovf=%b want 0/0", bus.press_count, bus.overflow);
    end
  endtask

  task automatic test_make_break();
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b0)); exp_press++;
    checks++;
    if (bus.evt_valid !== 1'b1 || bus.fifo_level !== 4'd1) begin
      failures++; $display("FAIL mb_latency valid=%b level=%0d want 1/1", bus.evt_valid, bus.fifo_level);
    end
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b1, 1'b0));
    checks++;
    if (bus.press_count !== 8'(exp_press)) begin
      failures++; $display("FAIL mb_press got=%0d want=%0d", bus.press_count, exp_press);
    end
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0); exp_q.push_back(mk(8'h75, 1'b1, 1'b0, 1'b0)); exp_press++;
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0); exp_q.push_back(mk(8'h75, 1'b1, 1'b1, 1'b0));
    checks++;
    if (bus.fifo_level !== 4'd4 || bus.press_count !== 8'(exp_press)) begin
      failures++; $display("FAIL mb_level level=%0d press=%0d want 4/%0d", bus.fifo_level, bus.press_count, exp_press);
    end
    for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
      if (bus.evt_valid === 1'b1) begin
        got = {bus.evt_code, bus.evt_ext, bus.evt_break, bus.evt_repeat};
        exp_evt = exp_q.pop_front();
        checks++;
        if (got !== exp_evt) begin failures++; $display("FAIL mb_event got=%h want=%h", got, exp_evt); end
        bus.evt_ready = 1'b1;
      end else begin
        bus.evt_ready = 1'b0;
      end
      @(negedge clk);
    end
    bus.evt_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.evt_valid !== 1'b0) begin
      failures++; $display("FAIL mb_drain left=%0d valid=%b want 0/0", exp_q.size(), bus.evt_valid); exp_q.delete();
    end
  endtask

  task automatic test_typematic();
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b0)); exp_press++;
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b1));
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b1));
    checks++;
    if (bus.press_count !== 8'(exp_press)) begin
      failures++; $display("FAIL tm_press_rpt got=%0d want=%0d", bus.press_count, exp_press);
    end
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b1, 1'b0));
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b0)); exp_press++;
    checks++;
    if (bus.press_count !== 8'(exp_press)) begin
      failures++; $display("FAIL tm_press got=%0d want=%0d", bus.press_count, exp_press);
    end
    for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
      if (bus.evt_valid === 1'b1) begin
        got = {bus.evt_code, bus.evt_ext, bus.evt_break, bus.evt_repeat};
        exp_evt = exp_q.pop_front();
        checks++;
        if (got !== exp_evt) begin failures++; $display("FAIL tm_event got=%h want=%h", got, exp_evt); end
        bus.evt_ready = 1'b1;
      end else begin
        bus.evt_ready = 1'b0;
      end
      @(negedge clk);
    end
    bus.evt_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.evt_valid !== 1'b0) begin
      failures++; $display("FAIL tm_drain left=%0d valid=%b want 0/0", exp_q.size(), bus.evt_valid); exp_q.delete();
    end
  endtask

  // Held key is 1C (pressed) on entry
  task automatic test_timeout_err();
    send(8'hF0, 1'b0);
    repeat (TO - 1) @(negedge clk);
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b1, 1'b0));
    send(8'hF0, 1'b0);
    repeat (TO) @(negedge clk);
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b0)); exp_press++;
    send(8'hF0, 1'b0);
    send(8'h55, 1'b1);
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b1));
    checks++;
    if (bus.press_count !== 8'(exp_press)) begin
      failures++; $display("FAIL to_press got=%0d want=%0d", bus.press_count, exp_press);
    end
    for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
      if (bus.evt_valid === 1'b1) begin
        got = {bus.evt_code, bus.evt_ext, bus.evt_break, bus.evt_repeat};
        exp_evt = exp_q.pop_front();
        checks++;
        if (got !== exp_evt) begin failures++; $display("FAIL to_event got=%h want=%h", got, exp_evt); end
        bus.evt_ready = 1'b1;
      end else begin
        bus.evt_ready = 1'b0;
      end
      @(negedge clk);
    end
    bus.evt_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.evt_valid !== 1'b0) begin
      failures++; $display("FAIL to_drain left=%0d valid=%b want 0/0", exp_q.size(), bus.evt_valid); exp_q.delete();
    end
  endtask

  // Full-rate prefix combinations; held key is 1C on entry
  task automatic test_back_to_back();
    send(8'hF0, 1'b0); send(8'hE0, 1'b0);
    send(8'h75, 1'b0); exp_q.push_back(mk(8'h75, 1'b1, 1'b0, 1'b0)); exp_press++;
    send(8'hE0, 1'b0); send(8'hE0, 1'b0);
    send(8'h75, 1'b0); exp_q.push_back(mk(8'h75, 1'b1, 1'b0, 1'b1));
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'hE0, 1'b0);
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b0)); exp_press++;
    send(8'hF0, 1'b0); send(8'hF0, 1'b0);
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b1, 1'b0));
    checks++;
    if (bus.fifo_level !== 4'd4 || bus.press_count !== 8'(exp_press)) begin
      failures++; $display("FAIL bb_level level=%0d press=%0d want 4/%0d", bus.fifo_level, bus.press_count, exp_press);
    end
    for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
      if (bus.evt_valid === 1'b1) begin
        got = {bus.evt_code, bus.evt_ext, bus.evt_break, bus.evt_repeat};
        exp_evt = exp_q.pop_front();
        checks++;
        if (got !== exp_evt) begin failures++; $display("FAIL bb_event got=%h want=%h", got, exp_evt); end
        bus.evt_ready = 1'b1;
      end else begin
        bus.evt_ready = 1'b0;
      end
      @(negedge clk);
    end
    bus.evt_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.evt_valid !== 1'b0) begin
      failures++; $display("FAIL bb_drain left=%0d valid=%b want 0/0", exp_q.size(), bus.evt_valid); exp_q.delete();
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      send(8'h40 + 8'(i), 1'b0);
      if (i < DEPTH) exp_q.push_back(mk(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0));
      exp_press++;
    end
    checks++;
    if (bus.fifo_level !== 4'd8 || bus.overflow !== 1'b1 || bus.press_count !== 8'(exp_press)) begin
      failures++; $display("FAIL ov_full level=%0d ovf=%b press=%0d want 8/1/%0d",
                           bus.fifo_level, bus.overflow, bus.press_count, exp_press);
    end
    got = {bus.evt_code, bus.evt_ext, bus.evt_break, bus.evt_repeat};
    exp_evt = exp_q.pop_front();
    checks++;
    if (got !== exp_evt) begin failures++; $display("FAIL ov_head got=%h want=%h", got, exp_evt); end
    bus.evt_ready = 1'b1;
    send(8'h50, 1'b0); exp_q.push_back(mk(8'h50, 1'b0, 1'b0, 1'b0)); exp_press++;
    bus.evt_ready = 1'b0;
    checks++;
    if (bus.fifo_level !== 4'd8 || bus.overflow !== 1'b1) begin
      failures++; $display("FAIL ov_pushpop level=%0d ovf=%b want 8/1", bus.fifo_level, bus.overflow);
    end
    for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
      if (bus.evt_valid === 1'b1) begin
        got = {bus.evt_code, bus.evt_ext, bus.evt_break, bus.evt_repeat};
        exp_evt = exp_q.pop_front();
        checks++;
        if (got !== exp_evt) begin failures++; $display("FAIL ov_event got=%h want=%h", got, exp_evt); end
        bus.evt_ready = 1'b1;
      end else begin
        bus.evt_ready = 1'b0;
      end
      @(negedge clk);
    end
    bus.evt_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.evt_valid !== 1'b0) begin
      failures++; $display("FAIL ov_drain left=%0d valid=%b want 0/0", exp_q.size(), bus.evt_valid); exp_q.delete();
    end
  endtask

  task automatic test_reset_midflight();
    send(8'h21, 1'b0); send(8'h22, 1'b0); send(8'h23, 1'b0);
    send(8'hF0, 1'b0);
    checks++;
    if (bus.fifo_level !== 4'd3) begin
      failures++; $display("FAIL rm_level got=%0d want=3", bus.fifo_level);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.evt_valid !== 1'b0 || bus.fifo_level !== 4'd0 || bus.press_count !== 8'd0 || bus.overflow !== 1'b0) begin
      failures++; $display("FAIL rm_async valid=%b level=%0d press=%0d ovf=%b want all 0",
                           bus.evt_valid, bus.fifo_level, bus.press_count, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_press = 0;
    send(8'h1C, 1'b0); exp_q.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b0)); exp_press++;
    checks++;
    if (bus.press_count !== 8'(exp_press)) begin
      failures++; $display("FAIL rm_press got=%0d want=%0d", bus.press_count, exp_press);
    end
    for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
      if (bus.evt_valid === 1'b1) begin
        got = {bus.evt_code, bus.evt_ext, bus.evt_break, bus.evt_repeat};
        exp_evt = exp_q.pop_front();
        checks++;
        if (got !== exp_evt) begin failures++; $display("FAIL rm_event got=%h want=%h", got, exp_evt); end
        bus.evt_ready = 1'b1;
      end else begin
        bus.evt_ready = 1'b0;
      end
      @(negedge clk);
    end
    bus.evt_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.evt_valid !== 1'b0) begin
      failures++; $display("FAIL rm_drain left=%0d valid=%b want 0/0", exp_q.size(), bus.evt_valid); exp_q.delete();
    end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_make_break();
    test_typematic();
    test_timeout_err();
    test_back_to_back();
    test_overflow();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scan_sequencer.md
# ps2_scan_sequencer

Sequencing controller between the PS/2 frame receiver and the display/consumer logic. Takes validated scan-code bytes, runs the make/break/extended prefix state machine, tags typematic repeats, counts fresh key presses and buffers decoded key events in a small FIFO. The FIFO feeds downstream consumers through a valid/ready handshake, so the serial receiver never stalls.

## Interface
- `FIFO_DEPTH`, default 8: number of event entries; must be a power of 2, ≥2.
- `TIMEOUT_CYC`, default 100000: idle cycles after which a partial prefix sequence is abandoned.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `byte_valid`  in  1  one-cycle pulse: receiver delivered a frame.
- `byte_data`  in  8  scan byte; sampled only when `byte_valid`=1.
- `byte_err`  in  1  frame failed start/stop/parity; qualified by `byte_valid`.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts head this cycle.
- `evt_code`  out  8  scan code of head event.
- `evt_ext`  out  1  head event had the E0 prefix.
- `evt_break`  out  1  head is a release event; 0 means press.
- `evt_repeat`  out  1  head is a typematic repeat of the held key.
- `press_count`  out  8  count of non-repeat press events; wraps 0xFF→0x00.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Each `byte_valid` with `byte_err`=0 causes one transition:
  - IDLE:
    - 0xE0 → GOT_E0.
    - 0xF0 → GOT_F0.
    - Any other byte: emit press with ext=0; stay in IDLE.
  - GOT_E0:
    - 0xF0 → GOT_E0F0.
    - 0xE0 → stay in GOT_E0.
    - Any other byte: emit press with ext=1 → IDLE.
  - GOT_F0:
    - 0xF0 → stay in GOT_F0.
    - 0xE0 → GOT_E0.
    - Any other byte: emit break with ext=0 → IDLE.
  - GOT_E0F0:
    - 0xE0 or 0xF0 → IDLE, no event.
    - Any other byte: emit break with ext=1 → IDLE.
- `byte_err`=1 with `byte_valid`: from any state → IDLE. No event is emitted and the held-key state is unchanged.
- Timeout: in a non-IDLE state with no `byte_valid` for TIMEOUT_CYC consecutive cycles, the FSM goes → IDLE. The counter clears on every `byte_valid`.
- Held-key register `{held_v, held_ext, held_code}`:
  - Press matching the held ext/code with held_v=1: repeat=1.
  - Other press: repeat=0, and the register loads the new key with held_v=1.
  - Break matching the held key: held_v←0.
  - Break not matching the held key: register unchanged.
- `press_count` increments on each emitted press with repeat=0. It increments at decode time, even if the FIFO then drops the event.
- FIFO:
  - Push when an event is emitted.
  - Pop when `evt_valid` & `evt_ready`.
  - Push while full with a simultaneous pop: accepted.
  - Push while full without a pop: dropped, and `overflow`←1. `overflow` clears only on reset.
- Outputs `evt_*` reflect the FIFO head (show-ahead). They are undefined-free: all zeros when empty.

## Timing
- Reset values: FSM=IDLE, held_v=0, FIFO empty, `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_break`=0, `evt_repeat`=0, `press_count`=0, `fifo_level`=0, `overflow`=0.
- Latency: a `byte_valid` in cycle N that emits an event gives `evt_valid`=1 in cycle N+1 when the FIFO was empty. The event appears at the FIFO tail otherwise.
- `press_count` and `fifo_level` update in cycle N+1.
- Back-to-back `byte_valid` on every cycle is supported at full rate.
- Pop and push in the same cycle: `fifo_level` is unchanged, and the head advances to the next entry.
- Reset asserted mid-sequence or with a non-empty FIFO: all state returns immediately to the reset values.

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum;
  - constants `PS2_PFX_EXT`=8'hE0 and `PS2_PFX_BRK`=8'hF0;
  - the packed event struct `{code[7:0], ext, brk, rpt}` (11 bits).
- Sub-module `ps2_evt_fifo`: parameterised synchronous FIFO of the event struct with show-ahead output, level and full/empty flags. The top level holds the FSM, timeout counter, held-key register and press counter.

## Test plan
- Bytes 1C, F0, 1C → events {1C,ext0,brk0,rpt0}, {1C,ext0,brk1,rpt0}; `press_count`=1.
- Bytes E0, 75, E0, F0, 75 → {75,ext1,brk0}, {75,ext1,brk1}; no event for any prefix byte.
- Bytes 1C, 1C, 1C → rpt=0,1,1; `press_count`=1. Then F0 1C, 1C → break, then press with rpt=0; `press_count`=2.
- `evt_ready`=0, 9 presses with DEPTH=8 → `fifo_level`=8, `overflow`=1, ninth event lost. Then full with push and pop in the same cycle → level stays 8, `overflow` unchanged.
- F0 then TIMEOUT_CYC idle cycles, then 1C → press (not break).
- F0 followed by a byte with `byte_err`=1, then 1C → press only.
- Reset asserted with 3 events queued → `evt_valid`=0 and `fifo_level`=0 immediately.
